// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM behind valid/ready request and response
// channels. It serves one request at a time, inserts WAIT_STATES cycles
// between accept and access, and flags misaligned, out-of-range and
// illegal-width accesses as errors.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is high only in IDLE. rsp_valid is high only in RESP.
// rsp_rdata and rsp_err are registers, so they hold steady until the
// response handshake.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t      state, state_next;
  logic [3:0]  wait_cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic        cur_write;
  logic [31:0] cur_addr;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_wdata;
  logic [AW-1:0] word_idx;
  logic [31:0] mem_word;
  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v;
  logic [31:0] merged;
  logic        width_ok, align_ok, range_ok, acc_err;
  logic        enter_resp, mem_we;

  assign dbg_state = state;

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: if (wait_cnt == WS) state_next = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register and wait counter (counts 1..WAIT_STATES while in WAIT).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_next;
      if (state_next == S_WAIT) wait_cnt <= (state == S_WAIT) ? wait_cnt + 4'd1 : 4'd1;
      else wait_cnt <= 4'd0;
    end
  end

  // Capture the request on accept; later input changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_write  <= 1'b0;
      lat_addr   <= 32'd0;
      lat_funct3 <= 3'd0;
      lat_wdata  <= 32'd0;
    end else if (state == S_IDLE && req_valid) begin
      lat_write  <= req_write;
      lat_addr   <= req_addr;
      lat_funct3 <= req_funct3;
      lat_wdata  <= req_wdata;
    end
  end

  // Access operands: live inputs when going straight from IDLE to RESP,
  // otherwise the captured request.
  always_comb begin
    cur_write  = (state == S_IDLE) ? req_write  : lat_write;
    cur_addr   = (state == S_IDLE) ? req_addr   : lat_addr;
    cur_funct3 = (state == S_IDLE) ? req_funct3 : lat_funct3;
    cur_wdata  = (state == S_IDLE) ? req_wdata  : lat_wdata;
  end

  // Legality, load extraction and store lane merge.
  always_comb begin
    word_idx = cur_addr[AW+1:2];
    mem_word = mem[word_idx];
    shifted  = mem_word >> {cur_addr[1:0], 3'b000};
    byte_v   = shifted[7:0];
    half_v   = cur_addr[1] ? mem_word[31:16] : mem_word[15:0];

    range_ok = (cur_addr[31:2] < 30'(DEPTH_WORDS));
    if (cur_write) width_ok = (cur_funct3 <= 3'b010);
    else width_ok = (cur_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    case (cur_funct3[1:0])
      2'b01:   align_ok = !cur_addr[0];
      2'b10:   align_ok = (cur_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    acc_err = !(width_ok && align_ok && range_ok);

    case (cur_funct3)
      3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_v = {{16{half_v[15]}}, half_v};
      3'b010:  load_v = mem_word;
      3'b100:  load_v = {24'd0, byte_v};
      3'b101:  load_v = {16'd0, half_v};
      default: load_v = 32'd0;
    endcase

    merged = mem_word;
    case (cur_funct3[1:0])
      2'b00:   merged[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
      2'b01:   merged[{cur_addr[1], 4'b0000} +: 16] = cur_wdata[15:0];
      default: merged = cur_wdata;
    endcase

    enter_resp = (state != S_RESP) && (state_next == S_RESP);
    mem_we     = enter_resp && cur_write && !acc_err && reset;
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= merged;
  end

  // Response registers: loaded on entry to RESP, cleared after the handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_rdata <= (acc_err || cur_write) ? 32'd0 : load_v;
      rsp_err   <= acc_err;
    end else if (state == S_RESP && rsp_ready) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_STATES 1, 3, 0) share one
// request bus; sel picks which instance sees req_valid/rsp_ready and whose
// outputs are observed.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b0;
  int          sel = 0;

  logic        ready_a [3];
  logic        valid_a [3];
  logic [31:0] rdata_a [3];
  logic        err_a [3];
  logic [1:0]  st_a [3];
  logic [2:0]  v_vec, r_vec;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  // Clock.
  always #5 clk = ~clk;

  assign v_vec[0] = req_valid && (sel == 0);
  assign v_vec[1] = req_valid && (sel == 1);
  assign v_vec[2] = req_valid && (sel == 2);
  assign r_vec[0] = rsp_ready && (sel == 0);
  assign r_vec[1] = rsp_ready && (sel == 1);
  assign r_vec[2] = rsp_ready && (sel == 2);
  assign req_ready = ready_a[sel];
  assign rsp_valid = valid_a[sel];
  assign rsp_rdata = rdata_a[sel];
  assign rsp_err   = err_a[sel];
  assign dbg_state = st_a[sel];

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut_ws1 (
    .clk(clk), .reset(reset), .req_valid(v_vec[0]), .req_ready(ready_a[0]),
    .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3),
    .req_wdata(req_wdata), .rsp_valid(valid_a[0]), .rsp_ready(r_vec[0]),
    .rsp_rdata(rdata_a[0]), .rsp_err(err_a[0]), .dbg_state(st_a[0]));

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut_ws3 (
    .clk(clk), .reset(reset), .req_valid(v_vec[1]), .req_ready(ready_a[1]),
    .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3),
    .req_wdata(req_wdata), .rsp_valid(valid_a[1]), .rsp_ready(r_vec[1]),
    .rsp_rdata(rdata_a[1]), .rsp_err(err_a[1]), .dbg_state(st_a[1]));

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .reset(reset), .req_valid(v_vec[2]), .req_ready(ready_a[2]),
    .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3),
    .req_wdata(req_wdata), .rsp_valid(valid_a[2]), .rsp_ready(r_vec[2]),
    .rsp_rdata(rdata_a[2]), .rsp_err(err_a[2]), .dbg_state(st_a[2]));

  // Driver: one full transaction. lat = cycles from accept edge to the
  // first cycle with rsp_valid high.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    int k;
    @(negedge clk);
    req_write = w; req_addr = a; req_funct3 = f3; req_wdata = wd; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    rd = rsp_rdata;
    er = rsp_err;
    n_checks++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL rsp_timeout addr=%h got rsp_valid=0 exp 1 within 40 cycles", a);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    sel = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_access();
    logic [31:0] rd; logic er; int lat;
    sel = 0;
    do_req(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL sw10_err got %b exp 0", er); end
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL sw10_rdata got %h exp 0", rd); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL sw10_latency got %0d exp 2", lat); end
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw10_rdata got %h exp deadbeef", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL lw10_err got %b exp 0", er); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL lw10_latency got %0d exp 2", lat); end
  endtask

  task automatic test_sub_word_loads();
    logic [31:0] rd; logic er; int lat;
    sel = 0;
    do_req(1'b0, 32'h13, 3'b000, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'hFFFFFFDE) begin n_fail++; $display("FAIL lb13 got %h exp ffffffde", rd); end
    do_req(1'b0, 32'h13, 3'b100, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h000000DE) begin n_fail++; $display("FAIL lbu13 got %h exp 000000de", rd); end
    do_req(1'b0, 32'h12, 3'b001, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'hFFFFDEAD) begin n_fail++; $display("FAIL lh12 got %h exp ffffdead", rd); end
    do_req(1'b0, 32'h10, 3'b101, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu10 got %h exp 0000beef", rd); end
    do_req(1'b0, 32'h11, 3'b000, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'hFFFFFFBE) begin n_fail++; $display("FAIL lb11 got %h exp ffffffbe", rd); end
  endtask

  task automatic test_sub_word_stores();
    logic [31:0] rd; logic er; int lat;
    sel = 0;
    do_req(1'b1, 32'h11, 3'b000, 32'hAAAAAA55, rd, er, lat);
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL sb11_err got %b exp 0", er); end
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL after_sb got %h exp dead55ef", rd); end
    do_req(1'b1, 32'h12, 3'b001, 32'hBBBB1234, rd, er, lat);
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h123455EF) begin n_fail++; $display("FAIL after_sh got %h exp 123455ef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    sel = 0;
    do_req(1'b0, 32'h12, 3'b010, 32'h0, rd, er, lat);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL lw12_err got %b exp 1", er); end
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL lw12_rdata got %h exp 0", rd); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL lw12_latency got %0d exp 2", lat); end
    do_req(1'b1, 32'h11, 3'b010, 32'h99999999, rd, er, lat);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL sw11_err got %b exp 1", er); end
    do_req(1'b0, 32'h11, 3'b001, 32'h0, rd, er, lat);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL lh11_err got %b exp 1", er); end
    do_req(1'b1, 32'h10, 3'b011, 32'h77777777, rd, er, lat);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL st_f3_011_err got %b exp 1", er); end
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h123455EF) begin n_fail++; $display("FAIL unchanged_after_err got %h exp 123455ef", rd); end
    do_req(1'b0, 32'h1000, 3'b010, 32'h0, rd, er, lat);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL lw_oor_err got %b exp 1", er); end
    do_req(1'b0, 32'hFFC, 3'b010, 32'h0, rd, er, lat);
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL lw_last_err got %b exp 0", er); end
    do_req(1'b0, 32'h10, 3'b011, 32'h0, rd, er, lat);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL ld_f3_011_err got %b exp 1", er); end
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL ld_f3_011_rdata got %h exp 0", rd); end
    do_req(1'b0, 32'h10, 3'b110, 32'h0, rd, er, lat);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL ld_f3_110_err got %b exp 1", er); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    sel = 0;
    @(negedge clk);
    req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_early_valid got %b exp 0", rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_at_2 got %b exp 1", rsp_valid); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc %0d got %b exp 1", i, rsp_valid); end
      n_checks++; if (rsp_rdata !== 32'h123455EF) begin n_fail++; $display("FAIL bp_hold_rdata cyc %0d got %h exp 123455ef", i, rsp_rdata); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready cyc %0d got %b exp 0", i, req_ready); end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after got %b exp 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_after got %b exp 0", rsp_valid); end
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h123455EF) begin n_fail++; $display("FAIL bp_no_second_accept got %h exp 123455ef", rd); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic er; int lat;
    sel = 1;
    do_req(1'b1, 32'h20, 3'b010, 32'h11112222, rd, er, lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL ws3_latency got %0d exp 4", lat); end
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_wdata = 32'hA5A5A5A5; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL ws3_in_wait got %0d exp 1", dbg_state); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_ready got %b exp 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got %b exp 0", rsp_valid); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL async_rst_state got %0d exp 0", dbg_state); end
    @(negedge clk);
    reset = 1'b1;
    do_req(1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h11112222) begin n_fail++; $display("FAIL uncommitted_store got %h exp 11112222", rd); end
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL ws3_load_latency got %0d exp 4", lat); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic er; int lat;
    sel = 2;
    do_req(1'b1, 32'h20, 3'b010, 32'hCAFEF00D, rd, er, lat);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL ws0_store_latency got %0d exp 1", lat); end
    do_req(1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ws0_load got %h exp cafef00d", rd); end
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL ws0_load_latency got %0d exp 1", lat); end
    do_req(1'b0, 32'h22, 3'b000, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL ws0_lb22 got %h exp fffffffe", rd); end
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_wdata = 32'h0BADF00D; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL ws0_valid_next got %b exp 1", rsp_valid); end
    reset = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ws0_rst_valid got %b exp 0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ws0_rst_ready got %b exp 1", req_ready); end
    @(negedge clk);
    reset = 1'b1;
    do_req(1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL committed_store got %h exp 0badf00d", rd); end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Test sequence and final report.
  initial begin
    test_reset();
    test_word_access();
    test_sub_word_loads();
    test_sub_word_stores();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    test_zero_wait();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
